impulse_scheduler: RTL

IMPULSE_SCHEDULER -- requirements
Module: impulse_scheduler

---
 rtl/impulse_scheduler_if.sv | 46 ++++
 rtl/impulse_scheduler.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/impulse_scheduler_if.sv
// Command-load and DDS handshake bundle for the impulse scheduler.
// The host/DDS side uses master, the scheduler uses slave.
interface impulse_scheduler_if;
  logic        wr_data;
  logic [63:0] mem_time_start;
  logic [15:0] mem_n_impuls;
  logic [31:0] mem_tblank1;
  logic [31:0] mem_interval_ti;
  logic [31:0] mem_tblank2;
  logic [31:0] mem_interval_tp;
  logic        ack;
  logic        req;
  logic        dds_start;
  logic        en_iz;
  logic        en_pr;

  modport master (
    output wr_data,
    output mem_time_start,
    output mem_n_impuls,
    output mem_tblank1,
    output mem_interval_ti,
    output mem_tblank2,
    output mem_interval_tp,
    output ack,
    input  req,
    input  dds_start,
    input  en_iz,
    input  en_pr
  );

  modport slave (
    input  wr_data,
    input  mem_time_start,
    input  mem_n_impuls,
    input  mem_tblank1,
    input  mem_interval_ti,
    input  mem_tblank2,
    input  mem_interval_tp,
    input  ack,
    output req,
    output dds_start,
    output en_iz,
    output en_pr
  );
endinterface

// File: rtl/impulse_scheduler.sv
// Timed impulse-train sequencer: DDS load handshake, start-time arming,
// then N repetitions of BLANK1 -> TX -> BLANK2 -> RX counted in TICKs.
module impulse_scheduler #(
  parameter int unsigned ACK_TIMEOUT = 1024
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [63:0]        time_i,
  input  logic               tick_i,
  input  logic               abort_i,
  impulse_scheduler_if.slave bus,
  output logic               busy_o,
  output logic               req_command_o,
  output logic               err_o,
  output logic [15:0]        imp_cnt_o
);

  localparam int unsigned TW = $clog2(ACK_TIMEOUT + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(ACK_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_ARMED,
    S_BLANK1,
    S_TX,
    S_BLANK2,
    S_RX,
    S_DONE
  } state_e;

  typedef struct packed {
    logic [63:0] start;
    logic [15:0] n;
    logic [31:0] tb1;
    logic [31:0] ti;
    logic [31:0] tb2;
    logic [31:0] tp;
  } cmd_t;

  state_e        state_q, state_d;
  cmd_t          cmd_q, cmd_d;
  logic [15:0]   imp_q, imp_d;
  logic [31:0]   ph_q, ph_d;
  logic [TW-1:0] to_q, to_d;

  logic req_q, req_d;
  logic dds_q, dds_d;
  logic iz_q, iz_d;
  logic pr_q, pr_d;
  logic busy_q, busy_d;
  logic rc_q, rc_d;
  logic err_q, err_d;

  logic [15:0] imp_inc;
  logic [31:0] ph_dec;
  logic        ph_end;

  always_comb begin
    state_d = state_q;
    cmd_d   = cmd_q;
    imp_d   = imp_q;
    ph_d    = ph_q;
    to_d    = to_q;
    err_d   = 1'b0;
    imp_inc = imp_q + 16'd1;
    ph_dec  = tick_i ? (ph_q - 32'd1) : ph_q;
    // A zero-length phase leaves after one cycle; otherwise on its last TICK
    ph_end  = (ph_q == 32'd0) || (tick_i && (ph_q == 32'd1));

    if (abort_i) begin
      state_d = S_IDLE;
    end else begin
      if (bus.wr_data && (state_q != S_IDLE)) begin
        err_d = 1'b1;
      end
      unique case (state_q)
        S_IDLE: begin
          if (bus.wr_data) begin
            if (bus.mem_n_impuls != 16'd0) begin
              cmd_d.start = bus.mem_time_start;
              cmd_d.n     = bus.mem_n_impuls;
              cmd_d.tb1   = bus.mem_tblank1;
              cmd_d.ti    = bus.mem_interval_ti;
              cmd_d.tb2   = bus.mem_tblank2;
              cmd_d.tp    = bus.mem_interval_tp;
              imp_d       = 16'd0;
              to_d        = '0;
              state_d     = S_LOAD;
            end else begin
              err_d = 1'b1;
            end
          end
        end
        S_LOAD: begin
          if (bus.ack) begin
            state_d = S_ARMED;
          end else if (to_q == TO_LAST) begin
            state_d = S_IDLE;
            err_d   = 1'b1;
          end else begin
            to_d = to_q + TW'(1);
          end
        end
        S_ARMED: begin
          if (time_i >= cmd_q.start) begin
            state_d = S_BLANK1;
            ph_d    = cmd_q.tb1;
          end
        end
        S_BLANK1: begin
          if (ph_end) begin
            state_d = S_TX;
            ph_d    = cmd_q.ti;
          end else begin
            ph_d = ph_dec;
          end
        end
        S_TX: begin
          if (ph_end) begin
            state_d = S_BLANK2;
            ph_d    = cmd_q.tb2;
          end else begin
            ph_d = ph_dec;
          end
        end
        S_BLANK2: begin
          if (ph_end) begin
            state_d = S_RX;
            ph_d    = cmd_q.tp;
          end else begin
            ph_d = ph_dec;
          end
        end
        S_RX: begin
          if (ph_end) begin
            imp_d = imp_inc;
            if (imp_inc == cmd_q.n) begin
              state_d = S_DONE;
            end else begin
              state_d = S_BLANK1;
              ph_d    = cmd_q.tb1;
            end
          end else begin
            ph_d = ph_dec;
          end
        end
        S_DONE: begin
          state_d = S_IDLE;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end

    // Outputs are registered copies of the next-state decode
    req_d  = (state_d == S_LOAD);
    iz_d   = (state_d == S_TX);
    pr_d   = (state_d == S_RX);
    dds_d  = (state_d == S_TX) && (state_q != S_TX);
    busy_d = (state_d != S_IDLE);
    rc_d   = (state_d == S_DONE);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      cmd_q   <= '0;
      imp_q   <= 16'd0;
      ph_q    <= 32'd0;
      to_q    <= '0;
      req_q   <= 1'b0;
      dds_q   <= 1'b0;
      iz_q    <= 1'b0;
      pr_q    <= 1'b0;
      busy_q  <= 1'b0;
      rc_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
      imp_q   <= imp_d;
      ph_q    <= ph_d;
      to_q    <= to_d;
      req_q   <= req_d;
      dds_q   <= dds_d;
      iz_q    <= iz_d;
      pr_q    <= pr_d;
      busy_q  <= busy_d;
      rc_q    <= rc_d;
      err_q   <= err_d;
    end
  end

  assign bus.req       = req_q;
  assign bus.dds_start = dds_q;
  assign bus.en_iz     = iz_q;
  assign bus.en_pr     = pr_q;
  assign busy_o        = busy_q;
  assign req_command_o = rc_q;
  assign err_o         = err_q;
  assign imp_cnt_o     = imp_q;

endmodule
